// File: rtl/vga_decoder.sv
// vga_decoder: recovers pixel coordinates and colour from a VGA stream in the
// clk25 domain. It also checks sync timing against the configured mode and
// reports lock and sticky timing errors.
//
// Ports
//   clk25, rst            pixel clock, synchronous active-high reset
//   hsync, vsync          active-low syncs, synchronous to clk25
//   red, green, blue      4-bit colour inputs
//   err_clr               one-cycle pulse, clears the sticky error flags
//   px_x, px_y, px_color  coordinates and {r,g,b} of the qualified pixel
//   px_valid              pixel qualifier, one per visible cycle while locked
//   frame_start           pulse with pixel (0,0) of each locked frame
//   locked                timing lock
//   err_*                 sticky timing error flags
//   frame_count           completed locked frames (wraps)
//   frame_crc, crc_valid  only when VGA_DECODER_CRC_EN is defined: CRC-16-CCITT
//                         of each locked frame, with a one-cycle strobe
//
// Optional feature macro: VGA_DECODER_CRC_EN
//
// Position convention: hpos is the column position of the current cycle,
// where the hsync-fall cycle is position 0. hcnt holds the previous cycle's
// hpos, so "previous hcnt + 1" at a fall is the line period in clocks.

module vga_decoder #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int HSP         = 96,
  parameter int HBP         = 48,
  parameter int HFP         = 16,
  parameter int VSP         = 2,
  parameter int VBP         = 29,
  parameter int VFP         = 10,
  parameter int PIXEL_DELAY = 1,
  parameter int INT_WIDTH   = 16
) (
  input  logic                 clk25,
  input  logic                 rst,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [3:0]           red,
  input  logic [3:0]           green,
  input  logic [3:0]           blue,
  input  logic                 err_clr,
  output logic [INT_WIDTH-1:0] px_x,
  output logic [INT_WIDTH-1:0] px_y,
  output logic [11:0]          px_color,
  output logic                 px_valid,
  output logic                 frame_start,
  output logic                 locked,
  output logic                 err_hpulse,
  output logic                 err_hperiod,
  output logic                 err_vpulse,
  output logic                 err_vperiod,
  output logic [31:0]          frame_count
`ifdef VGA_DECODER_CRC_EN
  ,
  output logic [15:0]          frame_crc,
  output logic                 crc_valid
`endif
);

  localparam int H_TOTAL = WIDTH + HSP + HBP + HFP;
  localparam int V_TOTAL = HEIGHT + VSP + VBP + VFP;

  localparam logic [INT_WIDTH-1:0] ONE       = INT_WIDTH'(1);
  localparam logic [INT_WIDTH-1:0] HSP_C     = INT_WIDTH'(HSP);
  localparam logic [INT_WIDTH-1:0] VSP_C     = INT_WIDTH'(VSP);
  localparam logic [INT_WIDTH-1:0] H_TOTAL_C = INT_WIDTH'(H_TOTAL);
  localparam logic [INT_WIDTH-1:0] V_TOTAL_C = INT_WIDTH'(V_TOTAL);
  localparam logic [INT_WIDTH-1:0] H_MAX_C   = INT_WIDTH'(2 * H_TOTAL);
  localparam logic [INT_WIDTH-1:0] X0_C      = INT_WIDTH'(HSP + HBP + PIXEL_DELAY);
  localparam logic [INT_WIDTH-1:0] X_END_C   = INT_WIDTH'(HSP + HBP + PIXEL_DELAY + WIDTH);
  localparam logic [INT_WIDTH-1:0] Y0_C      = INT_WIDTH'(VSP + VBP);
  localparam logic [INT_WIDTH-1:0] Y_END_C   = INT_WIDTH'(VSP + VBP + HEIGHT);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t               state;
  logic                 hsync_q, vsync_q;
  logic [INT_WIDTH-1:0] hcnt, vcnt;
  logic                 hskip;     // skip the period check on the first hsync fall
  logic                 acq_fail;  // a check failed since entering ACQUIRE

  logic                 hfall, hrise, vfall, vrise;
  logic [INT_WIDTH-1:0] hpos, vpos, cx, cy;
  logic                 chk_on, e_hpulse, e_hperiod, e_vpulse, e_vperiod, fail;
  logic                 samp, fc_inc;

  always_comb begin
    hfall = hsync_q & ~hsync;
    hrise = ~hsync_q & hsync;
    vfall = vsync_q & ~vsync;
    vrise = ~vsync_q & vsync;

    hpos = hfall ? '0 : ((hcnt == H_MAX_C) ? hcnt : hcnt + ONE);
    // vsync fall wins over a coincident hsync fall
    vpos = vfall ? '0 : (hfall ? vcnt + ONE : vcnt);

    chk_on    = (state != UNLOCKED);
    e_hpulse  = chk_on & hrise & (hpos != HSP_C);
    // hpos can only hit the saturation value on the cycle it first gets there
    e_hperiod = chk_on & ((hfall & ~hskip & (hcnt + ONE != H_TOTAL_C)) |
                          ((hpos == H_MAX_C) & (hcnt != H_MAX_C)));
    e_vpulse  = chk_on & vrise & (vpos != VSP_C);
    e_vperiod = chk_on & vfall & (vcnt + ONE != V_TOTAL_C);
    fail      = e_hpulse | e_hperiod | e_vpulse | e_vperiod;

    cx = hpos - X0_C;
    cy = vpos - Y0_C;
    // A failing edge drops the pixel in the same cycle so px_valid is low
    // together with locked.
    samp = (state == LOCKED) & ~fail &
           (hpos >= X0_C) & (hpos < X_END_C) &
           (vpos >= Y0_C) & (vpos < Y_END_C);
    fc_inc = vfall & (state == LOCKED) & ~fail;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state       <= UNLOCKED;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      hcnt        <= '0;
      vcnt        <= '0;
      hskip       <= 1'b0;
      acq_fail    <= 1'b0;
      locked      <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_color    <= '0;
      px_valid    <= 1'b0;
      frame_start <= 1'b0;
      err_hpulse  <= 1'b0;
      err_hperiod <= 1'b0;
      err_vpulse  <= 1'b0;
      err_vperiod <= 1'b0;
      frame_count <= '0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      hcnt    <= hpos;
      vcnt    <= vpos;

      px_valid    <= samp;
      frame_start <= samp & (cx == '0) & (cy == '0);
      if (samp) begin
        px_x     <= cx;
        px_y     <= cy;
        px_color <= {red, green, blue};
      end

      // a new error in the clearing cycle still sets the flag
      err_hpulse  <= (err_hpulse  & ~err_clr) | e_hpulse;
      err_hperiod <= (err_hperiod & ~err_clr) | e_hperiod;
      err_vpulse  <= (err_vpulse  & ~err_clr) | e_vpulse;
      err_vperiod <= (err_vperiod & ~err_clr) | e_vperiod;

      if (fc_inc) frame_count <= frame_count + 32'd1;

      case (state)
        UNLOCKED: begin
          locked <= 1'b0;
          if (vfall) begin
            state    <= ACQUIRE;
            hskip    <= 1'b1;
            acq_fail <= 1'b0;
          end
        end
        ACQUIRE: begin
          if (vfall) begin
            if (!acq_fail && !fail) begin
              state  <= LOCKED;
              locked <= 1'b1;
              hskip  <= 1'b0;
            end else begin
              // restart the measurement window from this vsync fall
              hskip    <= 1'b1;
              acq_fail <= 1'b0;
            end
          end else begin
            if (fail)  acq_fail <= 1'b1;
            if (hfall) hskip    <= 1'b0;
          end
        end
        LOCKED: begin
          if (fail) begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_DECODER_CRC_EN
  // CRC-16-CCITT (0x1021), MSB first, over one 16-bit word
  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc;

  // Runs on the registered pixel stream, so the frame's last pixel is
  // folded in long before the frame-ending vsync fall latches it.
  always_ff @(posedge clk25) begin
    if (rst) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= fc_inc;
      if (fc_inc) frame_crc <= crc;
      if (!locked)
        crc <= 16'hFFFF;
      else if (px_valid)
        crc <= crc16_word(frame_start ? 16'hFFFF : crc, {4'h0, px_color});
    end
  end
`endif

endmodule

// File: tb/tb_vga_decoder.sv
// Scoreboard bench for vga_decoder on a reduced video mode so that whole
// frames are cheap. Expected pixels are queued when the stream generator
// drives a visible cycle and popped when the DUT raises px_valid.

module tb_vga_decoder;
  localparam int W = 8, H = 4, HSP = 3, HBP = 2, HFP = 2;
  localparam int VSP = 2, VBP = 3, VFP = 2, PD = 1, IW = 16;
  localparam int HT = W + HSP + HBP + HFP;
  localparam int VT = H + VSP + VBP + VFP;
  localparam int X0 = HSP + HBP + PD;
  localparam int Y0 = VSP + VBP;

  logic          clk25, rst, hsync, vsync, err_clr;
  logic [3:0]    red, green, blue;
  logic [IW-1:0] px_x, px_y;
  logic [11:0]   px_color;
  logic          px_valid, frame_start, locked;
  logic          err_hpulse, err_hperiod, err_vpulse, err_vperiod;
  logic [31:0]   frame_count;
`ifdef VGA_DECODER_CRC_EN
  logic [15:0]   frame_crc;
  logic          crc_valid;
`endif

  vga_decoder #(
    .WIDTH(W), .HEIGHT(H), .HSP(HSP), .HBP(HBP), .HFP(HFP),
    .VSP(VSP), .VBP(VBP), .VFP(VFP), .PIXEL_DELAY(PD), .INT_WIDTH(IW)
  ) dut (
    .clk25(clk25), .rst(rst), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .err_clr(err_clr),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .px_valid(px_valid),
    .frame_start(frame_start), .locked(locked),
    .err_hpulse(err_hpulse), .err_hperiod(err_hperiod),
    .err_vpulse(err_vpulse), .err_vperiod(err_vperiod),
    .frame_count(frame_count)
`ifdef VGA_DECODER_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  typedef struct packed {
    logic [IW-1:0] x;
    logic [IW-1:0] y;
    logic [11:0]   c;
    logic          fs;
  } pix_t;

  pix_t        exp_q[$];
  int          errors = 0, checks = 0, npix = 0;
  int          fc_exp = 0;
  logic [3:0]  err_exp = '0;   // {hpulse, hperiod, vpulse, vperiod}
  bit          clr_req = 1'b0;
`ifdef VGA_DECODER_CRC_EN
  int          fc_prev = 0;
  logic [15:0] last_crc = 16'hFFFF;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] px);
    logic [15:0] d;
    d = {4'h0, px};
    for (int i = 15; i >= 0; i--)
      c = (c[15] ^ d[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: every qualified pixel must match the head of the queue.
  always @(negedge clk25) begin
    if (px_valid) begin
      pix_t got, want;
      got = {px_x, px_y, px_color, frame_start};
      if (exp_q.size() == 0) begin
        check("px_valid_unexpected", px_valid, 1'b0);
      end else begin
        want = exp_q.pop_front();
        check("pixel", got, want);
        npix++;
      end
    end
  end

  // One frame of nlines lines. bad_hsp>0 shortens the hsync pulse on
  // bad_line; bad_hsp==0 holds hsync high through bad_line and the next line.
  // Returns early (without driving) at (stop_l, stop_k).
  task automatic frame(input int nlines, input bit exp_lk, input bit exp_px,
                       input int bad_line = 1000, input int bad_hsp = HSP,
                       input int stop_l = -1, input int stop_k = -1);
    int npush = 0;
    bit hold;
    int hs_len;
    logic [3:0] xr, yr;
`ifdef VGA_DECODER_CRC_EN
    logic [15:0] crc_acc = 16'hFFFF;
    bit crc_due;
`endif
    for (int l = 0; l < nlines; l++) begin
      for (int k = 0; k < HT; k++) begin
        @(negedge clk25);
        if (l == stop_l && k == stop_k) return;
        // effects of the previous cycle
        if (l == 0 && k == 1) begin
          check("locked", locked, exp_lk);
          check("frame_count", frame_count, fc_exp);
          check("err_flags", {err_hpulse, err_hperiod, err_vpulse, err_vperiod}, err_exp);
`ifdef VGA_DECODER_CRC_EN
          crc_due = (fc_exp == fc_prev + 1);
          check("crc_valid", crc_valid, crc_due);
          if (crc_due) check("frame_crc", frame_crc, last_crc);
          fc_prev = fc_exp;
`endif
        end
        if (bad_hsp > 0 && l == bad_line && k == bad_hsp)
          check("locked_before_drop", locked, 1'b1);
        if (bad_hsp > 0 && l == bad_line && k == bad_hsp + 1) begin
          check("err_hpulse", err_hpulse, 1'b1);
          check("locked_drop", locked, 1'b0);
        end
        if (bad_hsp == 0 && l == bad_line + 1 && k < 2)
          check("err_hperiod_sat", err_hperiod, k == 1);
        if (bad_hsp == 0 && l == bad_line + 1 && k == 1)
          check("locked_drop", locked, 1'b0);

        hold   = (bad_hsp == 0) && (l == bad_line || l == bad_line + 1);
        hs_len = (l == bad_line && bad_hsp > 0) ? bad_hsp : HSP;
        hsync  = hold ? 1'b1 : (k >= hs_len);
        vsync  = (l >= VSP);
        // clear requests: at frame start, and on the bad-pulse rise cycle
        err_clr = (l == 0 && k == 0 && clr_req) ||
                  (bad_hsp > 0 && l == bad_line && k == bad_hsp);
        if (l >= Y0 && l < Y0 + H && k >= X0 && k < X0 + W) begin
          xr = 4'(k - X0);
          yr = 4'(l - Y0);
          {red, green, blue} = {xr, 4'h0, yr};
          if (exp_px && l < bad_line) begin
            exp_q.push_back({IW'(k - X0), IW'(l - Y0), {xr, 4'h0, yr},
                             (k == X0 && l == Y0)});
            npush++;
`ifdef VGA_DECODER_CRC_EN
            crc_acc = crc_step(crc_acc, {xr, 4'h0, yr});
`endif
          end
        end else begin
          {red, green, blue} = 12'($urandom);
        end
      end
    end
    check("px_count", npix, npush);
    check("px_missing", exp_q.size(), 0);
    exp_q.delete();
    npix    = 0;
    clr_req = 1'b0;
`ifdef VGA_DECODER_CRC_EN
    if (exp_px && npush == W * H) last_crc = crc_acc;
`endif
  endtask

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; err_clr = 1'b0;
    {red, green, blue} = '0;
    repeat (3) @(negedge clk25);
    check("rst_locked", locked, 1'b0);
    check("rst_px_valid", px_valid, 1'b0);
    check("rst_frame_count", frame_count, 0);
    check("rst_err", {err_hpulse, err_hperiod, err_vpulse, err_vperiod}, 0);
    check("rst_px", {px_x, px_y, px_color, frame_start}, 0);
    rst = 1'b0;

    // clean stream: acquire, lock, count
    frame(VT, 1'b0, 1'b0);
    frame(VT, 1'b1, 1'b1);
    fc_exp = 1; frame(VT, 1'b1, 1'b1);
    // short hsync pulse on visible line 1, with err_clr on the same cycle
    fc_exp = 2; frame(VT, 1'b1, 1'b1, Y0 + 1, HSP - 1);
    err_exp = 4'b1000; frame(VT, 1'b0, 1'b0);
    frame(VT, 1'b1, 1'b1);
    clr_req = 1'b1; err_exp = '0; fc_exp = 3; frame(VT, 1'b1, 1'b1);
    // hsync held high until hcnt saturates at 2*H_TOTAL
    fc_exp = 4; frame(VT, 1'b1, 1'b1, Y0 + 1, 0);
    err_exp = 4'b0100; frame(VT, 1'b0, 1'b0);
    frame(VT, 1'b1, 1'b1);
    // one line short: vperiod error at the ending vsync fall, no count
    clr_req = 1'b1; err_exp = '0; fc_exp = 5; frame(VT - 1, 1'b1, 1'b1);
    err_exp = 4'b0001; frame(VT, 1'b0, 1'b0);
    frame(VT, 1'b0, 1'b0);
    frame(VT, 1'b1, 1'b1);
    // reset in the middle of a locked frame at pixel (3,2)
    fc_exp = 6; frame(VT, 1'b1, 1'b1, 1000, HSP, Y0 + 2, X0 + 3);
    rst = 1'b1;
    @(negedge clk25);
    check("midrst_locked", locked, 1'b0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_err", {err_hpulse, err_hperiod, err_vpulse, err_vperiod}, 0);
    check("midrst_px", {px_x, px_y, px_color, px_valid, frame_start}, 0);
    rst = 1'b0;
    exp_q.delete();
    npix = 0;
    fc_exp = 0; err_exp = '0; frame(VT, 1'b0, 1'b0);
    frame(VT, 1'b1, 1'b1);
    fc_exp = 1; frame(VT, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_decoder.md
# vga_decoder

Recovers pixel coordinates and colour from a 640x480 VGA stream (hsync, vsync, 12-bit RGB) in the 25 MHz pixel domain. It checks sync timing against the configured mode and reports lock and sticky timing errors. It is the receiving end of the GPU video output, used as an on-chip self-check and capture front-end. It outputs one qualified pixel per visible cycle, plus frame markers.

## Interface
Parameters:
- WIDTH, 640, visible columns
- HEIGHT, 480, visible lines
- HSP / HBP / HFP, 96 / 48 / 16, horizontal sync, back porch and front porch, in clocks
- VSP / VBP / VFP, 2 / 29 / 10, vertical sync, back porch and front porch, in lines
- PIXEL_DELAY, 1, clocks from the start of a visible column (relative to the hsync fall) to valid RGB on the inputs
- INT_WIDTH, 16, coordinate and counter width

Ports:
- clk25  in  1  pixel clock, 25 MHz
- rst  in  1  reset, synchronous, active-high
- hsync, vsync  in  1  sync inputs, active-low, synchronous to clk25
- red, green, blue  in  4 each  colour inputs
- err_clr  in  1  one-cycle pulse; clears all sticky error flags
- px_x, px_y  out  INT_WIDTH  coordinates of the current pixel
- px_color  out  12  {red, green, blue}
- px_valid  out  1  pixel qualifier
- frame_start  out  1  one-cycle pulse on the first pixel of each locked frame
- locked  out  1  timing lock
- err_hpulse, err_hperiod, err_vpulse, err_vperiod  out  1  sticky error flags
- frame_count  out  32  number of completed locked frames, wraps

## Operation
- H_TOTAL = WIDTH+HSP+HBP+HFP = 800 and V_TOTAL = HEIGHT+VSP+VBP+VFP = 521.
- Edge detect: each sync input has a registered copy. A fall is sync==0 with previous==1; a rise is the reverse.
- hcnt:
  - Set to 0 on an hsync fall; otherwise increments.
  - Saturates at 2*H_TOTAL.
- vcnt:
  - Set to 0 on a vsync fall.
  - Otherwise increments on each hsync fall.
  - When both falls occur in the same cycle, vsync wins: vcnt=0 and hcnt=0.
- Checks (each active only in ACQUIRE and LOCKED):
  - hsync rise: hcnt must equal HSP, else err_hpulse.
  - hsync fall: previous hcnt+1 must equal H_TOTAL, else err_hperiod. Skipped for the first fall after entering ACQUIRE.
  - hcnt reaching 2*H_TOTAL sets err_hperiod.
  - vsync rise: vcnt must equal VSP, else err_vpulse.
  - vsync fall: lines since the last vsync fall must equal V_TOTAL, else err_vperiod.
- State machine:
  - UNLOCKED: on a vsync fall, go to ACQUIRE.
  - ACQUIRE: at the next vsync fall, go to LOCKED if no check failed since entry. Otherwise stay in ACQUIRE and restart the measurement.
  - LOCKED: any failed check sets its flag and moves to UNLOCKED in the next cycle.
- Sampling:
  - Column c is sampled when hcnt == HSP+HBP+PIXEL_DELAY+c, for c in 0..WIDTH-1.
  - Line r corresponds to vcnt == VSP+VBP+r, for r in 0..HEIGHT-1.
- Pixel output:
  - px_valid is 1 only when in LOCKED and both conditions above hold.
  - px_x=c, px_y=r, px_color is the sampled RGB.
- frame_start is asserted with the pixel (0,0).
- frame_count increments on the vsync fall that ends a frame which was LOCKED throughout.
- Error flags:
  - Flags are sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, the flag is set.

## Timing
- Reset values: all outputs 0, state UNLOCKED, hcnt=vcnt=0, sync history registers=1.
- Latency: all pixel outputs are registered, valid one clk25 after the sampled input cycle.
- Lock latency after reset with a clean stream: locked rises one cycle after the second vsync fall.
- Loss of lock: locked falls one cycle after the failing edge. px_valid is 0 from that cycle onward.
- Reset mid-frame: everything returns to the reset values. No partial frame is counted.

## Configuration
- VGA_DECODER_CRC_EN:
  - When defined, adds outputs frame_crc [15:0] and crc_valid.
  - frame_crc is a CRC-16-CCITT (polynomial 0x1021, init 0xFFFF) over px_color zero-extended to 16 bits, for every valid pixel of a locked frame.
  - frame_crc latches on the frame-ending vsync fall; crc_valid pulses for 1 cycle.
  - The CRC reinitialises on frame_start and on loss of lock. Reset value is 0.
  - When not defined, these ports and their logic are absent.

## Test plan
- Ideal 800x521 stream, colour = x[3:0]<<8 | y[3:0]:
  - locked=1 after the 2nd vsync fall.
  - Exactly 307200 px_valid per frame.
  - px_x/px_y/px_color match the stream; frame_count increments once per frame.
- Stream with the hsync pulse shortened to 95 clocks on line 100 of a locked frame:
  - err_hpulse=1 and locked=0 in the next cycle.
  - Re-lock after 2 clean vsync falls; flag remains set until err_clr.
- hsync held high for 1600 clocks: err_hperiod set at hcnt=1600, lock lost.
- Frame with 520 lines: err_vperiod at the vsync fall; frame_count unchanged for that frame.
- rst asserted at x=300,y=200: all outputs 0 in the next cycle, and px_valid stays 0 until re-lock.
- With CRC enabled, all-0x8CE frame: frame_crc equals the software CRC over 307200 words of 0x08CE, and crc_valid pulses once.
